// File: rtl/multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier slice.
// Holds the default operand width, the derived counter width and the
// control-FSM state encodings used by the control FSM and the bench.
package multiplier_pkg;

  localparam int WORD_LENGTH = 8;
  localparam int CNT_WIDTH   = $clog2(WORD_LENGTH);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    SHIFT      = 3'd2,
    FINISH     = 3'd3,
    SYNC_RESET = 3'd4
  } state_e;

endpackage

// File: rtl/multiplier_if.sv
// Control/data bundle between the multiplier control FSM (master) and the
// shift-and-add datapath (slave).
interface multiplier_if #(
  parameter int WORD_LENGTH = multiplier_pkg::WORD_LENGTH
);

  logic                       load;
  logic                       shift;
  logic                       sync_reset;
  logic                       enable;
  logic                       ready;
  logic [WORD_LENGTH-1:0]     multiplicand;
  logic [WORD_LENGTH-1:0]     multiplier;
  logic                       flag;
  logic [2*WORD_LENGTH-1:0]   product;

  modport master (
    output load, shift, sync_reset, enable, ready, multiplicand, multiplier,
    input  flag, product
  );

  modport slave (
    input  load, shift, sync_reset, enable, ready, multiplicand, multiplier,
    output flag, product
  );

endinterface

// File: rtl/multiplier_counter.sv
// Iteration counter for the shift-and-add datapath. Counts add/shift
// iterations and raises flag while the last one is being performed.
module multiplier_counter
  import multiplier_pkg::*;
#(
  parameter int WORD_LENGTH = multiplier_pkg::WORD_LENGTH,
  parameter int CW          = $clog2(WORD_LENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sync_reset,
  input  logic          enable,
  input  logic          load,
  input  logic          shift,
  output logic [CW-1:0] count,
  output logic          flag
);

  localparam logic [CW-1:0] LAST_CNT = CW'(WORD_LENGTH - 1);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;

  // Increment with explicit wrap at the last iteration so non power-of-two widths behave.
  always_comb begin
    count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
    if (count_r == LAST_CNT) begin
      count_next_s = {CW{1'b0}};
    end else begin
      count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Counter register: sync clear beats arm, arm beats increment; a load suppresses the iteration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CW{1'b0}};
    end else if (!sync_reset) begin
      count_r <= {CW{1'b0}};
    end else if (enable) begin
      count_r <= {CW{1'b0}};
    end else if (shift && !load) begin
      count_r <= count_next_s;
    end
  end

  assign count = count_r;
  assign flag  = shift & (count_r == LAST_CNT);

endmodule

// File: rtl/multiplier_datapath.sv
// Shift-and-add multiplier datapath, responder to the Moore control FSM.
// Build option: define SIGNED_MULT_EN for two's complement operands
// (magnitudes are multiplied, the sign is re-applied at product capture).
// The default build is unsigned only.
module multiplier_datapath
  import multiplier_pkg::*;
#(
  parameter int WORD_LENGTH = multiplier_pkg::WORD_LENGTH
) (
  input  logic        clk,
  input  logic        reset,
  multiplier_if.slave bus
);

  localparam int W  = WORD_LENGTH;
  localparam int PW = 2 * WORD_LENGTH;
  localparam int CW = $clog2(WORD_LENGTH);

  logic [PW-1:0] a_sr_r;
  logic [W-1:0]  b_sr_r;
  logic [PW-1:0] acc_r;
  logic [PW-1:0] product_r;
  logic [PW-1:0] a_load_s;
  logic [W-1:0]  b_load_s;
  logic [PW-1:0] result_s;
  logic [CW-1:0] count_s;
  logic          flag_s;

`ifdef SIGNED_MULT_EN
  logic          sign_r;
  logic          sign_load_s;
  logic [PW-1:0] a_ext_s;

  // Operand magnitudes. A is widened to 2W (>= W+1) bits before negation so
  // -2^(W-1) becomes +2^(W-1); for B the W-bit negate of -2^(W-1) read as
  // unsigned is that same magnitude, so W bits suffice in b_sr.
  always_comb begin
    a_ext_s     = {{W{bus.multiplicand[W-1]}}, bus.multiplicand};
    sign_load_s = bus.multiplicand[W-1] ^ bus.multiplier[W-1];
    if (bus.multiplicand[W-1]) begin
      a_load_s = ~a_ext_s + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      a_load_s = a_ext_s;
    end
    if (bus.multiplier[W-1]) begin
      b_load_s = ~bus.multiplier + {{(W-1){1'b0}}, 1'b1};
    end else begin
      b_load_s = bus.multiplier;
    end
  end

  // Sign of the result, captured with the operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_r <= 1'b0;
    end else if (!bus.sync_reset) begin
      sign_r <= 1'b0;
    end else if (bus.load) begin
      sign_r <= sign_load_s;
    end
  end

  // Re-apply the sign to the unsigned accumulator at capture time.
  always_comb begin
    if (sign_r) begin
      result_s = ~acc_r + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      result_s = acc_r;
    end
  end
`else
  // Unsigned operands load straight in; A is zero-extended to 2W bits.
  always_comb begin
    a_load_s = {{W{1'b0}}, bus.multiplicand};
    b_load_s = bus.multiplier;
    result_s = acc_r;
  end
`endif

  // Working registers: sync clear, then load (discarding any partial sum), then one add/shift step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sr_r <= {PW{1'b0}};
      b_sr_r <= {W{1'b0}};
      acc_r  <= {PW{1'b0}};
    end else if (!bus.sync_reset) begin
      a_sr_r <= {PW{1'b0}};
      b_sr_r <= {W{1'b0}};
      acc_r  <= {PW{1'b0}};
    end else if (bus.load) begin
      a_sr_r <= a_load_s;
      b_sr_r <= b_load_s;
      acc_r  <= {PW{1'b0}};
    end else if (bus.shift) begin
      if (b_sr_r[0]) begin
        acc_r <= acc_r + a_sr_r;
      end
      a_sr_r <= {a_sr_r[PW-2:0], 1'b0};
      b_sr_r <= {1'b0, b_sr_r[W-1:1]};
    end
  end

  // Product register: captured only in FINISH (ready with sync_reset inactive), held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      product_r <= {PW{1'b0}};
    end else if (bus.ready && bus.sync_reset) begin
      product_r <= result_s;
    end
  end

  multiplier_counter #(
    .WORD_LENGTH (W),
    .CW          (CW)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .sync_reset (bus.sync_reset),
    .enable     (bus.enable),
    .load       (bus.load),
    .shift      (bus.shift),
    .count      (count_s),
    .flag       (flag_s)
  );

  assign bus.flag    = flag_s;
  assign bus.product = product_r;

  // count is kept visible at this level for debug probing only.
  logic unused_count_s;
  assign unused_count_s = ^count_s;

endmodule

// File: tb/tb_multiplier_datapath.sv
// Directed testbench for multiplier_datapath. Plays the control FSM
// (IDLE/LOAD/SHIFT/FINISH/SYNC_RESET) and checks flag and product against
// hand-computed values. Signed vectors run when SIGNED_MULT_EN is defined.
module tb_multiplier_datapath;
  import multiplier_pkg::*;

  localparam int W  = WORD_LENGTH;
  localparam int PW = 2 * WORD_LENGTH;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_flag_r = 1'b0;

  multiplier_if #(.WORD_LENGTH(W)) mif ();

  multiplier_datapath #(.WORD_LENGTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  always #5 clk = ~clk;

  // Remember whether the last iteration was flagged, to catch shifting past it.
  always @(posedge clk) prev_flag_r <= mif.flag & ~mif.load;

  // Shift continuing after flag would wrap the counter: protocol violation.
  always @(negedge clk) begin
    if (reset) begin
      assert (!(prev_flag_r && mif.shift && !mif.load))
        else $error("protocol violation: shift continued after flag");
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input state_e st, input logic [W-1:0] a, input logic [W-1:0] b);
    mif.load         = (st == LOAD);
    mif.enable       = (st == LOAD);
    mif.shift        = (st == SHIFT);
    mif.ready        = (st == FINISH) || (st == SYNC_RESET);
    mif.sync_reset   = (st != SYNC_RESET);
    mif.multiplicand = a;
    mif.multiplier   = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // W shifts, FINISH, SYNC_RESET, IDLE; product must hold prev until the FINISH edge.
  task automatic finish_mult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [PW-1:0] prev, input logic [PW-1:0] exp,
                             input bit acc_zero);
    for (int i = 0; i < W; i++) begin
      drive(SHIFT, a, b);
      @(negedge clk);
      check($sformatf("%s flag shift%0d", tag, i + 1), mif.flag, (i == W - 1) ? 1 : 0);
      if (acc_zero) check($sformatf("%s acc shift%0d", tag, i + 1), dut.acc_r, 0);
      if (i == W - 1) check($sformatf("%s hold before finish", tag), mif.product, prev);
      tick();
    end
    drive(FINISH, a, b);
    @(negedge clk);
    check($sformatf("%s flag in finish", tag), mif.flag, 0);
    tick();
    drive(SYNC_RESET, a, b);
    @(negedge clk);
    check($sformatf("%s product", tag), mif.product, exp);
    tick();
    drive(IDLE, a, b);
    @(negedge clk);
    check($sformatf("%s product held idle", tag), mif.product, exp);
    tick();
  endtask

  task automatic run_mult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [PW-1:0] prev, input logic [PW-1:0] exp,
                          input bit acc_zero);
    drive(LOAD, a, b);
    @(negedge clk);
    check($sformatf("%s hold in load", tag), mif.product, prev);
    tick();
    finish_mult(tag, a, b, prev, exp, acc_zero);
  endtask

  initial begin
    // Reset state.
    reset = 1'b0;
    drive(IDLE, 8'd0, 8'd0);
    tick();
    tick();
    check("reset product", mif.product, 0);
    check("reset flag", mif.flag, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // 13 * 11 = 143, held through IDLE.
    run_mult("13x11", 8'd13, 8'd11, 16'd0, 16'h008F, 1'b0);
    tick();
    check("143 held after idle", mif.product, 16'h008F);

    // Old product must survive LOAD/SHIFT of 2 * 2.
    run_mult("2x2", 8'd2, 8'd2, 16'h008F, 16'd4, 1'b0);

    // Zero multiplicand: accumulator never moves.
    run_mult("0x200", 8'd0, 8'd200, 16'd4, 16'd0, 1'b1);

    // Full-scale operands (in signed build: -1 * -1).
`ifdef SIGNED_MULT_EN
    run_mult("255x255", 8'd255, 8'd255, 16'd0, 16'd1, 1'b0);
`else
    run_mult("255x255", 8'd255, 8'd255, 16'd0, 16'hFE01, 1'b0);
`endif

    // Asynchronous reset on the 4th shift of 13 * 11.
    drive(LOAD, 8'd13, 8'd11);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(SHIFT, 8'd13, 8'd11);
      tick();
    end
    drive(SHIFT, 8'd13, 8'd11);
    @(negedge clk);
`ifdef SIGNED_MULT_EN
    check("pre-reset product", mif.product, 16'd1);
`else
    check("pre-reset product", mif.product, 16'hFE01);
`endif
    reset = 1'b0;
    #1;
    check("mid reset product", mif.product, 0);
    check("mid reset flag", mif.flag, 0);
    drive(IDLE, 8'd0, 8'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
    run_mult("7x6", 8'd7, 8'd6, 16'd0, 16'd42, 1'b0);

    // Reload during the 5th shift discards the partial 13 * 11 sum.
    drive(LOAD, 8'd13, 8'd11);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(SHIFT, 8'd13, 8'd11);
      tick();
    end
    drive(LOAD, 8'd3, 8'd5);
    mif.shift = 1'b1;
    @(negedge clk);
    check("reload flag", mif.flag, 0);
    tick();
    finish_mult("reload 3x5", 8'd3, 8'd5, 16'd42, 16'd15, 1'b0);

`ifdef SIGNED_MULT_EN
    run_mult("-3x5", 8'hFD, 8'd5, 16'd15, 16'hFFF1, 1'b0);
    run_mult("-128x-128", 8'h80, 8'h80, 16'hFFF1, 16'h4000, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
